// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//
// Shares one external combinational W-bit adder between NUM_REQ requesters.
// A two-stage pipeline sits around the adder:
//   OP stage : registered operands of the granted requester. They drive the
//              adder's interleaved input bus, so the adder only ever sees
//              stable register outputs.
//   RS stage : registered adder result with the issuing requester ID. It is
//              held under downstream backpressure.
//
// Build option:
//   ADDER_ARB_FIXED_PRIO_EN - when defined, the lowest valid index always
//   wins and there is no round-robin pointer. When undefined, arbitration is
//   round-robin starting at rr_ptr.
//
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   req_valid  - per-requester operand valid
//   req_ready  - per-requester accept (one-hot or zero)
//   req_a/b    - packed operands, slice i = [i*W +: W]
//   add_in     - to adder, bit 2k = a[k], bit 2k+1 = b[k]
//   add_out    - from adder, [W-1:0] sum, [W] carry out
//   rsp_*      - registered result, carry, requester ID, valid/ready
//   busy       - either pipeline stage holds a valid entry

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 12,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [2*W-1:0]       add_in,
  input  logic [W:0]           add_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_cout,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  logic            op_vld;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [ID_W-1:0] op_id;

  logic            rs_adv;
  logic            op_adv;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // RS can take a new value when it is empty or being popped this cycle;
  // OP can take a new value when it is empty or its content moves into RS.
  assign rs_adv = ~rsp_valid | rsp_ready;
  assign op_adv = ~op_vld | rs_adv;
  assign busy   = op_vld | rsp_valid;

  // Arbitration: scan requesters starting at the priority origin (rr_ptr,
  // or index 0 in the fixed-priority build) and pick the first valid one.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      idx = ID_W'(k);
`else
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
`endif
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Only the winner sees ready, and nobody does while OP is stalled, so a
  // request is never taken unless it is actually loaded on this edge.
  always_comb begin
    req_ready = '0;
    if (op_adv && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // OP stage. With no grant the operands are held so the adder inputs do
  // not toggle while idle; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_vld <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
    end else if (op_adv) begin
      op_vld <= grant_found;
      if (grant_found) begin
        op_a  <= req_a[int'(grant_idx)*W +: W];
        op_b  <= req_b[int'(grant_idx)*W +: W];
        op_id <= grant_idx;
      end
    end
  end

`ifndef ADDER_ARB_FIXED_PRIO_EN
  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (op_adv && grant_found) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + ID_W'(1);
      end
    end
  end
`endif

  // RS stage. Data only changes when a real result is captured; a pop with
  // nothing behind it just clears the valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else if (rs_adv) begin
      rsp_valid <= op_vld;
      if (op_vld) begin
        rsp_sum  <= add_out[W-1:0];
        rsp_cout <= add_out[W];
        rsp_id   <= op_id;
      end
    end
  end

  // Interleave operand bits onto the adder bus.
  always_comb begin
    add_in = '0;
    for (int k = 0; k < W; k++) begin
      add_in[2*k]   = op_a[k];
      add_in[2*k+1] = op_b[k];
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
//
// Bench for adder_share_arbiter. Models the shared external adder, drives
// directed operand vectors and pushes hand-computed expected responses into
// a queue; a monitor pops and compares on every response handshake.
// The fixed-priority scenario is selected with ADDER_ARB_FIXED_PRIO_EN.

module tb_adder_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 12;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W-1:0]    sum;
    logic            cout;
  } rsp_t;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [2*W-1:0]       add_in;
  logic [W:0]           add_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W-1:0]         rsp_sum;
  logic                 rsp_cout;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];

  logic [W-1:0] tab_a    [NUM_REQ];
  logic [W-1:0] tab_b    [NUM_REQ];
  logic [W-1:0] tab_sum  [NUM_REQ];
  logic         tab_cout [NUM_REQ];

  adder_share_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_in    (add_in),
    .add_out   (add_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the shared adder: de-interleave and add.
  always_comb begin
    logic [W-1:0] a_bus;
    logic [W-1:0] b_bus;
    a_bus = '0;
    b_bus = '0;
    for (int k = 0; k < W; k++) begin
      a_bus[k] = add_in[2*k];
      b_bus[k] = add_in[2*k+1];
    end
    add_out = {1'b0, a_bus} + {1'b0, b_bus};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Load operand table entry with its hand-computed sum and carry.
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] sum, input logic cout);
    tab_a[i]    = a;
    tab_b[i]    = b;
    tab_sum[i]  = sum;
    tab_cout[i] = cout;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*W +: W] = tab_a[i];
      req_b[i*W +: W] = tab_b[i];
    end
    req_valid = valid;
  endtask

  task automatic push_exp(input int i);
    rsp_t e;
    e.id   = ID_W'(i);
    e.sum  = tab_sum[i];
    e.cout = tab_cout[i];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got id=%0d sum=0x%0h cout=%0d expected none",
                   rsp_id, rsp_sum, rsp_cout);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_data", 32'({rsp_id, rsp_sum, rsp_cout}), 32'(e));
        end
      end
    end
  end

  initial begin
    int first_id;
    int second_id;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, '0, '0, '0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_add_in", 32'(add_in), 0);
    checkOutput("rst_rsp_sum", 32'(rsp_sum), 0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 0);
    checkOutput("rst_rsp_cout", 32'(rsp_cout), 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-flight: accepted op must vanish without a response
    set_req(1, 12'h0FF, 12'h001, 12'h100, 1'b0);
    applyStimulus(4'b0010);
    @(negedge clk);
    checkOutput("midrst_ready", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(4'b0000);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("midrst_add_in", 32'(add_in), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    set_req(0, 12'h123, 12'h456, 12'h579, 1'b0);
    set_req(1, 12'h800, 12'h800, 12'h000, 1'b1);
    set_req(2, 12'hABC, 12'h111, 12'hBCD, 1'b0);
    set_req(3, 12'hFFF, 12'hFFF, 12'hFFE, 1'b1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    // Fixed priority: req 0 starves req 3 until it drops
    applyStimulus(4'b1001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("fixed_ready_0", 32'(req_ready), 32'h1);
      push_exp(0);
      tick();
    end
    applyStimulus(4'b1000);
    @(negedge clk);
    checkOutput("fixed_ready_3", 32'(req_ready), 32'h8);
    push_exp(3);
    tick();
    applyStimulus(4'b0000);
    repeat (4) tick();
`else
    // Round-robin fairness: grant order 0,1,2,3,... starting from pointer 0
    applyStimulus(4'b1111);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        checkOutput("rr_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
      end
      push_exp(k % 4);
      tick();
    end
    applyStimulus(4'b0000);
    repeat (4) tick();
`endif

    // Single op: 0xFFF + 0x001 wraps to 0 with carry, visible for one cycle
    set_req(2, 12'hFFF, 12'h001, 12'h000, 1'b1);
    applyStimulus(4'b0100);
    @(negedge clk);
    checkOutput("single_ready", 32'(req_ready), 32'h4);
    push_exp(2);
    tick();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("single_early", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    checkOutput("single_valid", 32'(rsp_valid), 1);
    checkOutput("single_id", 32'(rsp_id), 2);
    checkOutput("single_sum", 32'(rsp_sum), 32'h000);
    checkOutput("single_cout", 32'(rsp_cout), 1);
    tick();
    @(negedge clk);
    checkOutput("single_once", 32'(rsp_valid), 0);
    repeat (2) tick();

    // Sparse: req 3 alone, req 0 two cycles later; adder bus holds when idle
    set_req(3, 12'h00F, 12'h0F0, 12'h0FF, 1'b0);
    set_req(0, 12'h001, 12'h002, 12'h003, 1'b0);
    applyStimulus(4'b1000);
    @(negedge clk);
    checkOutput("sparse_ready3", 32'(req_ready), 32'h8);
    push_exp(3);
    tick();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("sparse_add_in", 32'(add_in), 32'h00AA55);
    tick();
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("sparse_add_hold", 32'(add_in), 32'h00AA55);
    checkOutput("sparse_rsp3", 32'({rsp_valid, rsp_id}), 32'h7);
    checkOutput("sparse_ready0", 32'(req_ready), 32'h1);
    push_exp(0);
    tick();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("sparse_gap", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    checkOutput("sparse_rsp0", 32'({rsp_valid, rsp_id}), 32'h4);
    repeat (2) tick();

    // Backpressure: two results pile up, then five more stalled cycles
    set_req(0, 12'h123, 12'h456, 12'h579, 1'b0);
    set_req(1, 12'h800, 12'h800, 12'h000, 1'b1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    first_id  = 0;
    second_id = 1;
`else
    first_id  = 1;
    second_id = 0;
`endif
    rsp_ready = 1'b0;
    applyStimulus(4'b0011);
    @(negedge clk);
    checkOutput("bp_ready_first", 32'(req_ready), 32'(1) << first_id);
    push_exp(first_id);
    tick();
    @(negedge clk);
    checkOutput("bp_ready_second", 32'(req_ready), 32'(1) << second_id);
    push_exp(second_id);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_ready_zero", 32'(req_ready), 0);
      checkOutput("bp_hold", 32'({rsp_valid, rsp_id, rsp_sum}),
                  32'({1'b1, ID_W'(first_id), tab_sum[first_id]}));
      tick();
    end
    rsp_ready = 1'b1;
    applyStimulus(4'b0000);
    repeat (4) tick();

    checkOutput("queue_drained", 32'(exp_q.size()), 0);
    checkOutput("idle_busy", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational 12-bit Brent-Kung adder between NUM_REQ requesters.
- Each requester presents operands with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and registers its operands onto the adder's interleaved input bus.
- The adder's 13-bit result is captured into a response register, returned with the requester ID, and subject to downstream backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 12, operand width; must match the shared adder.
- ID_W, 2, width of requester ID; equals clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*W  operand A; slice i = [i*W +: W].
- req_b  input  NUM_REQ*W  operand B, same packing.
- add_in  output  2*W  to adder: bit 2k = a[k], bit 2k+1 = b[k].
- add_out  input  W+1  from adder: [W-1:0] sum, [W] carry out.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  downstream accepts result.
- rsp_sum  output  W  registered sum.
- rsp_cout  output  1  registered carry out.
- rsp_id  output  ID_W  requester that issued this result.
- busy  output  1  high when either pipeline stage is valid.

Behaviour:
- Two stages:
  - Stage OP: op_vld, op_a, op_b, op_id. add_in is driven only from op_a/op_b, so the adder sees stable registered inputs.
  - Stage RS: rsp_valid, rsp_sum, rsp_cout, rsp_id.
- Reset (async, any time, including mid-operation):
  - op_vld=0, op_a=op_b=0, so add_in=0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0.
  - Round-robin pointer rr_ptr=0.
  - In-flight operations are discarded; no response is produced for them.
- Stall rules:
  - rs_adv = ~rsp_valid | rsp_ready.
  - op_adv = ~op_vld | rs_adv.
- Arbitration (combinational, when op_adv=1):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit g wins; req_ready[g]=1.
  - All other req_ready bits are 0, and all are 0 when op_adv=0.
- Accept: on req_valid[g] & req_ready[g], next edge loads op_a=req_a[g], op_b=req_b[g], op_id=g, op_vld=1, rr_ptr=(g+1) mod NUM_REQ.
- No grant while op_adv=1: op_vld becomes 0, rr_ptr is unchanged, op_a/op_b hold their values (no toggling on the adder inputs).
- Result capture: when op_vld & rs_adv, next edge loads rsp_sum=add_out[W-1:0], rsp_cout=add_out[W], rsp_id=op_id, rsp_valid=1.
- When rs_adv & ~op_vld: rsp_valid becomes 0.
- Latency and throughput:
  - Result appears 2 cycles after the accept edge.
  - Sustained throughput is 1 result per cycle while rsp_ready=1.
- Backpressure:
  - rsp_valid & ~rsp_ready freezes RS.
  - If op_vld is also set, OP freezes and all req_ready go to 0.
  - Response data is stable while rsp_valid & ~rsp_ready.
- Simultaneous pop and push: rsp_valid & rsp_ready & op_vld captures the new result in the same edge as the pop, with no bubble.
- Requester rules:
  - Requesters may drop req_valid without being granted; the arbiter never latches an ungranted request.
  - Operands are sampled only on the accept edge.
- Arithmetic: a + b is unsigned, W+1 bit result; no carry-in. Wrap-around is reported only via rsp_cout.
- busy = op_vld | rsp_valid.

Optional Feature:
- Macro ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with req_valid wins. rr_ptr is removed and held at 0. Starvation of higher indices is permitted.
- Undefined: round-robin as described above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Reset mid-flight: accept req 1 (a=0x0FF, b=0x001), assert rst the next cycle. Response: rsp_valid=0, add_in=0, rr_ptr=0, and no response ever appears for that request.
- Single op: req 2 with a=0xFFF, b=0x001, rsp_ready=1. Response: 2 cycles later rsp_valid=1, rsp_sum=0x000, rsp_cout=1, rsp_id=2, for exactly 1 cycle.
- Round-robin fairness: all 4 requesters hold valid continuously, rsp_ready=1. Response: grant order 0,1,2,3,0,1…, one response per cycle, rsp_id following the same order.
- Backpressure: results pending, rsp_ready=0 for 5 cycles. Response: rsp_sum/rsp_id held stable; req_ready=0 once OP is full. On rsp_ready=1, results drain in order with no loss or duplication.
- Sparse requests: req 3 valid alone, then req 0 two cycles later. Response: ids 3 then 0, each 2 cycles after its accept; add_in holds its last value while idle.
- Fixed-priority build (ADDER_ARB_FIXED_PRIO_EN): reqs 0 and 3 held valid continuously. Response: only req 0 is ever granted; req 3 is granted on the first cycle after req 0 deasserts.
